line_render_sched: RTL and testbench
====================================

// Module: line_render_sched
// PURPOSE
//  Per-scanline sequencer for the sprite line-buffer pipeline, driven by the video timing
//  generator's hbl/vc outputs. On every line start it swaps the ping-pong line buffers,
//  clears the back buffer and starts the sprite renderer for the next line (vc+1).
//  It also detects renderer overruns and aborts late jobs so display never stalls.
// PARAMETERS
//  VACT_FIRST  16     first rendered (visible) line number
//  VACT_LAST   239    last rendered (visible) line number
//  WDOG_CYC    4095   clk cycles allowed for clear+render before forced abort (max 65535)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  clk_pix     in   1  pixel clock enable, one clk wide; hbl/vc are valid when high
//  hbl         in   1  horizontal blank from timing generator
//  vc          in   9  current line number
//  clr_start   out  1  one-clk pulse: clear back line buffer
//  clr_done    in   1  one-clk pulse from clearer when finished
//  spr_start   out  1  one-clk pulse: render sprites into back buffer
//  spr_line    out  9  line being rendered, held stable from clr_start to job end
//  spr_done    in   1  one-clk pulse from renderer when finished
//  abort       out  1  one-clk pulse: clearer/renderer must drop current job
//  wr_bank     out  1  back (render) buffer select; display reads ~wr_bank
//  busy        out  1  high whenever FSM is not IDLE
//  overrun     out  1  sticky; set on any abort, cleared only by reset
//  ovr_cnt     out  8  saturating abort count (SCHED_STATS_EN only)
//  max_lat     out  16 worst trigger-to-done latency in clk cycles (SCHED_STATS_EN only)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; watchdog 0; internal hbl_q 0.
//  Line trigger T: clk_pix==1 && hbl==1 && hbl_q==0; hbl_q updates only when clk_pix==1.
//  On T: wr_bank toggles (every trigger, including vblank lines); target = vc+1 (9-bit wrap).
//  Job only if VACT_FIRST <= target <= VACT_LAST; otherwise the FSM stays/returns IDLE.
//  FSM states: IDLE, CLEAR, WAIT_CLR, RENDER, WAIT_RND.
//   IDLE -T & in range-> CLEAR; latch spr_line=target; watchdog=0.
//   CLEAR: clr_start=1 for exactly this cycle -> WAIT_CLR.
//   WAIT_CLR -clr_done-> RENDER.   RENDER: spr_start=1 one cycle -> WAIT_RND.
//   WAIT_RND -spr_done-> IDLE.  clr_start to spr_start latency: 1 clk after clr_done.
//  clr_done/spr_done are ignored outside their WAIT state.
//  Watchdog increments every clk outside IDLE; reaching WDOG_CYC -> abort pulse, overrun=1,
//   -> IDLE.
//  T while not IDLE: abort pulse same cycle, overrun=1, the job is discarded, then if in range
//   go directly to CLEAR with the new target (no IDLE cycle); else -> IDLE.
//  T coincident with spr_done in WAIT_RND: done wins (no abort), new job starts -> CLEAR.
//  Watchdog expiry coincident with T: one abort pulse only; T is handled as above.
//  Reset mid-job: immediate IDLE, no abort pulse, wr_bank=0.
//  spr_line changes only on entry to CLEAR.
// CONFIGURATION
//  `SCHED_STATS_EN defined: ovr_cnt increments per abort, saturating at 255; max_lat holds the max
//   count of clk cycles from T to spr_done (includes trigger cycle), saturating at 16'hFFFF.
//  Not defined: ovr_cnt and max_lat tied to 0, no counter logic; all other behaviour identical.
// TESTING
//  1 reset, then hbl rise at vc=20, clr_done after 5 clk, spr_done after 30 ->
//    clr_start at T+1, spr_start 1 clk after clr_done, spr_line=21, busy drops after done,
//    wr_bank=1.
//  2 hbl rise at vc=239 and at vc=262 -> no clr_start (targets 240, 263); wr_bank toggles each.
//  3 hbl rise at vc=99, withhold spr_done, next hbl at vc=100 -> abort pulse, overrun=1,
//    clr_start with spr_line=101.
//  4 WDOG_CYC=50, clr_done never arrives -> abort exactly 50 clk after CLEAR entry, FSM IDLE.
//  5 spr_done same cycle as next trigger -> no abort, overrun stays 0, new job starts.
//  6 stats: 300 forced aborts -> ovr_cnt=255; job with 40-clk latency -> max_lat=40;
//    reset mid-WAIT_RND -> all outputs 0.

Source files
------------

// File: rtl/line_render_sched.sv
// rtl/line_render_sched.sv - per-scanline line-buffer swap, clear and sprite render sequencer
// Optional abort/latency statistics (ovr_cnt, max_lat) are built only with `SCHED_STATS_EN.
module line_render_sched #(
  parameter int VACT_FIRST = 16,
  parameter int VACT_LAST  = 239,
  parameter int WDOG_CYC   = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_pix,
  input  logic        hbl,
  input  logic [8:0]  vc,
  output logic        clr_start,
  input  logic        clr_done,
  output logic        spr_start,
  output logic [8:0]  spr_line,
  input  logic        spr_done,
  output logic        abort,
  output logic        wr_bank,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  ovr_cnt,
  output logic [15:0] max_lat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_CLR,
    S_RENDER,
    S_WAIT_RND
  } state_t;

  state_t      state;
  logic        hbl_q;
  logic [15:0] wdog;
  logic        trig;
  logic        in_range;
  logic        wdog_exp;
  logic        done_now;
  logic        active;
  logic [8:0]  target;

  assign active   = (state != S_IDLE);
  assign trig     = clk_pix & hbl & ~hbl_q;
  assign target   = vc + 9'd1;
  assign in_range = (target >= 9'(VACT_FIRST)) && (target <= 9'(VACT_LAST));
  assign wdog_exp = active && (wdog == 16'(WDOG_CYC - 1));
  assign done_now = (state == S_WAIT_RND) && spr_done;

  // A completion always wins over a trigger or watchdog expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hbl_q     <= 1'b0;
      wdog      <= 16'd0;
      clr_start <= 1'b0;
      spr_start <= 1'b0;
      spr_line  <= 9'd0;
      abort     <= 1'b0;
      wr_bank   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      clr_start <= 1'b0;
      spr_start <= 1'b0;
      abort     <= 1'b0;
      if (clk_pix) hbl_q <= hbl;
      if (active) wdog <= wdog + 16'd1;
      if (trig) begin
        wr_bank <= ~wr_bank;
        if (active && !done_now) begin
          abort   <= 1'b1;
          overrun <= 1'b1;
        end
        if (in_range) begin
          state     <= S_CLEAR;
          clr_start <= 1'b1;
          spr_line  <= target;
          wdog      <= 16'd0;
          busy      <= 1'b1;
        end else begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end else if (done_now) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else if (wdog_exp) begin
        abort   <= 1'b1;
        overrun <= 1'b1;
        state   <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_CLEAR:    state <= S_WAIT_CLR;
          S_WAIT_CLR: begin
            if (clr_done) begin
              state     <= S_RENDER;
              spr_start <= 1'b1;
            end
          end
          S_RENDER:   state <= S_WAIT_RND;
          default:    ;
        endcase
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] lat_cnt;

  // lat_cnt is 1 in the cycle after the trigger, so it counts the trigger cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt <= 8'd0;
      max_lat <= 16'd0;
      lat_cnt <= 16'd0;
    end else begin
      if (abort && (ovr_cnt != 8'hFF)) ovr_cnt <= ovr_cnt + 8'd1;
      if (done_now && (lat_cnt > max_lat)) max_lat <= lat_cnt;
      if (trig && in_range) lat_cnt <= 16'd1;
      else if (active && (lat_cnt != 16'hFFFF)) lat_cnt <= lat_cnt + 16'd1;
    end
  end
`else
  assign ovr_cnt = 8'd0;
  assign max_lat = 16'd0;
`endif

endmodule

// File: tb/tb_line_render_sched.sv
// tb/tb_line_render_sched.sv - directed bench for line_render_sched with spr_line scoreboard
module tb_line_render_sched;

  localparam int WDOG = 50;
`ifdef SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_pix = 1'b0;
  logic        hbl = 1'b0;
  logic [8:0]  vc = 9'd0;
  logic        clr_done = 1'b0;
  logic        spr_done = 1'b0;
  logic        clr_start;
  logic        spr_start;
  logic [8:0]  spr_line;
  logic        abort;
  logic        wr_bank;
  logic        busy;
  logic        overrun;
  logic [7:0]  ovr_cnt;
  logic [15:0] max_lat;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic exp_bank = 1'b0;

  line_render_sched #(.VACT_FIRST(16), .VACT_LAST(239), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .reset(reset), .clk_pix(clk_pix), .hbl(hbl), .vc(vc),
    .clr_start(clr_start), .clr_done(clr_done), .spr_start(spr_start),
    .spr_line(spr_line), .spr_done(spr_done), .abort(abort), .wr_bank(wr_bank),
    .busy(busy), .overrun(overrun), .ovr_cnt(ovr_cnt), .max_lat(max_lat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every clr_start must carry the line the bench predicted for the oldest pending trigger.
  always @(negedge clk) begin
    if (!reset && clr_start === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_clr_start", 32'd1, 32'd0);
      else chk("sb_spr_line", 32'(spr_line), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Two pixel enables: hbl low then high; returns in the cycle after the trigger.
  task automatic hbl_rise(input logic [8:0] v, input logic with_done);
    logic [8:0] t;
    tick();
    clk_pix = 1'b1;
    hbl = 1'b0;
    vc = v;
    tick();
    hbl = 1'b1;
    spr_done = with_done;
    t = v + 9'd1;
    if (t >= 9'd16 && t <= 9'd239) exp_q.push_back(t);
    exp_bank = ~exp_bank;
    tick();
    clk_pix = 1'b0;
    spr_done = 1'b0;
  endtask

  task automatic do_clr_done();
    clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
  endtask

  task automatic do_spr_done();
    spr_done = 1'b1;
    tick();
    spr_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clr_start"}, 32'(clr_start), 32'd0);
    chk({tag, "_spr_start"}, 32'(spr_start), 32'd0);
    chk({tag, "_spr_line"}, 32'(spr_line), 32'd0);
    chk({tag, "_abort"}, 32'(abort), 32'd0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_ovr_cnt"}, 32'(ovr_cnt), 32'd0);
    chk({tag, "_max_lat"}, 32'(max_lat), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    at_neg();
    chk_all_zero("reset");
    reset = 1'b0;

    // normal job at vc=20
    hbl_rise(9'd20, 1'b0);
    at_neg();
    chk("t1_clr_start", 32'(clr_start), 32'd1);
    chk("t1_spr_line", 32'(spr_line), 32'd21);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_wr_bank", 32'(wr_bank), 32'(exp_bank));
    tick();
    at_neg();
    chk("t1_clr_start_pulse", 32'(clr_start), 32'd0);
    repeat (3) tick();
    at_neg();
    chk("t1_no_early_spr_start", 32'(spr_start), 32'd0);
    do_clr_done();
    at_neg();
    chk("t1_spr_start", 32'(spr_start), 32'd1);
    tick();
    at_neg();
    chk("t1_spr_start_pulse", 32'(spr_start), 32'd0);
    repeat (28) tick();
    at_neg();
    chk("t1_busy_wait", 32'(busy), 32'd1);
    do_spr_done();
    at_neg();
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_spr_line_hold", 32'(spr_line), 32'd21);
    chk("t1_wr_bank_end", 32'(wr_bank), 32'd1);

    // out-of-range targets still swap banks
    hbl_rise(9'd239, 1'b0);
    at_neg();
    chk("t2_clr_start_240", 32'(clr_start), 32'd0);
    chk("t2_busy_240", 32'(busy), 32'd0);
    chk("t2_wr_bank_240", 32'(wr_bank), 32'(exp_bank));
    hbl_rise(9'd262, 1'b0);
    at_neg();
    chk("t2_clr_start_263", 32'(clr_start), 32'd0);
    chk("t2_wr_bank_263", 32'(wr_bank), 32'(exp_bank));

    // spr_done coincident with the next trigger
    hbl_rise(9'd30, 1'b0);
    tick();
    do_clr_done();
    hbl_rise(9'd31, 1'b1);
    at_neg();
    chk("t5_abort", 32'(abort), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd0);
    chk("t5_clr_start", 32'(clr_start), 32'd1);
    chk("t5_spr_line", 32'(spr_line), 32'd32);
    tick();
    do_clr_done();
    tick();
    do_spr_done();
    at_neg();
    chk("t5_idle", 32'(busy), 32'd0);

    // watchdog expiry with clr_done withheld
    hbl_rise(9'd50, 1'b0);
    repeat (49) tick();
    at_neg();
    chk("t4_abort_early", 32'(abort), 32'd0);
    chk("t4_busy_before", 32'(busy), 32'd1);
    tick();
    at_neg();
    chk("t4_abort", 32'(abort), 32'd1);
    chk("t4_busy_after", 32'(busy), 32'd0);
    chk("t4_overrun", 32'(overrun), 32'd1);
    tick();
    at_neg();
    chk("t4_abort_pulse", 32'(abort), 32'd0);
    chk("t4_stay_idle", 32'(busy), 32'd0);

    // overrun: new line while rendering
    hbl_rise(9'd99, 1'b0);
    tick();
    do_clr_done();
    tick();
    tick();
    hbl_rise(9'd100, 1'b0);
    at_neg();
    chk("t3_abort", 32'(abort), 32'd1);
    chk("t3_overrun", 32'(overrun), 32'd1);
    chk("t3_clr_start", 32'(clr_start), 32'd1);
    chk("t3_spr_line", 32'(spr_line), 32'd101);
    tick();
    at_neg();
    chk("t3_abort_pulse", 32'(abort), 32'd0);
    do_clr_done();
    tick();
    do_spr_done();
    at_neg();
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_wr_bank", 32'(wr_bank), 32'(exp_bank));

    // statistics: saturating abort count and worst latency
    for (int i = 0; i < 300; i++) hbl_rise(9'd50, 1'b0);
    tick();
    at_neg();
    chk("t6_ovr_cnt", 32'(ovr_cnt), STATS ? 32'd255 : 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd1);
    hbl_rise(9'd60, 1'b0);
    tick();
    do_clr_done();
    repeat (37) tick();
    do_spr_done();
    at_neg();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_max_lat", 32'(max_lat), STATS ? 32'd40 : 32'd0);

    // reset in the middle of a render
    hbl_rise(9'd70, 1'b0);
    tick();
    do_clr_done();
    tick();
    at_neg();
    chk("t6_busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    at_neg();
    chk_all_zero("midreset");
    reset = 1'b0;
    tick();
    at_neg();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
